// File: rtl/multicycle_alu_if.sv
// ---------------------------------------------------------------------------
// multicycle_alu_if
// Purpose : groups the operation request/response handshake of the
//           multicycle ALU into one bundle.
// Signals : in_valid/in_ready   - request handshake (op, a, b qualified)
//           op[3:0], a, b       - opcode and operands
//           out_valid/out_ready - response handshake
//           result, result_hi   - primary / secondary result
//           overflow, zero, div0, illegal - status flags
// Modports: slave  - the ALU side
//           master - the requester/consumer side
// ---------------------------------------------------------------------------
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             overflow;
    logic             zero;
    logic             div0;
    logic             illegal;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
               overflow, zero, div0, illegal
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               overflow, zero, div0, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
// Purpose : WIDTH-bit ALU. Logic/add/sub/compare ops finish one cycle after
//           accept; unsigned multiply (shift-add) and unsigned divide
//           (restoring) iterate one bit per cycle and finish WIDTH+1 cycles
//           after accept. The result is held until the consumer takes it.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - multicycle_alu_if.slave (request + response handshake)
// Params  : WIDTH  - operand width (even, 8..64)
//           CNT_W  - iteration counter width, 2**CNT_W > WIDTH
// ---------------------------------------------------------------------------
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_alu_if.slave  bus
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    // lo/hi double as the iteration working registers and the final
    // result/result_hi; they are only meaningful while out_valid is high.
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             ill_q, ill_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic             started_q;

    logic [WIDTH-1:0] addSum;
    logic [WIDTH:0]   subFull;
    logic             addOvf, subOvf;
    logic [WIDTH-1:0] aluRes;
    logic             aluOvf, aluIll;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divFits;
    logic             inReady;

    // Single-cycle datapath, evaluated on the live request inputs so the
    // answer can be captured on the accept edge. SUB is a + ~b + 1, so the
    // carry out is the inverse of the borrow used for SLTU.
    always_comb begin
        addSum  = bus.a + bus.b;
        subFull = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        addOvf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (addSum[WIDTH-1] != bus.a[WIDTH-1]);
        subOvf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (subFull[WIDTH-1] != bus.a[WIDTH-1]);
        aluRes  = '0;
        aluOvf  = 1'b0;
        aluIll  = 1'b0;
        case (bus.op)
            OP_AND:  aluRes = bus.a & bus.b;
            OP_OR:   aluRes = bus.a | bus.b;
            OP_ADD:  begin aluRes = addSum; aluOvf = addOvf; end
            OP_SUB:  begin aluRes = subFull[WIDTH-1:0]; aluOvf = subOvf; end
            OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, subFull[WIDTH-1] ^ subOvf};
            OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, ~subFull[WIDTH]};
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_NOR:  aluRes = ~(bus.a | bus.b);
            OP_MULU, OP_DIVU: aluRes = '0;
            default: aluIll = 1'b1;
        endcase
    end

    // One iteration step of each multicycle algorithm. Multiply adds the
    // multiplicand into the high half when the current multiplier bit (lo[0])
    // is set, then shifts {carry,hi,lo} right. Divide shifts the next dividend
    // bit into the partial remainder and subtracts the divisor if it fits;
    // the quotient bit enters lo from the right as the dividend leaves it.
    // A fitting partial remainder is below 2*divisor, so the low WIDTH bits of
    // the difference are exact.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        divShift = {hi_q, lo_q[WIDTH-1]};
        divFits  = divShift >= {1'b0, opnd_q};
        divDiff  = divShift[WIDTH-1:0] - opnd_q;
    end

    assign inReady = (state_q == IDLE) && started_q;

    // State and datapath registers. Reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
            ill_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            div0_q    <= div0_d;
            ill_q     <= ill_d;
            started_q <= 1'b1;
        end
    end

    // Next-state logic. Inputs are only looked at on the accept cycle, so
    // request changes while busy cannot disturb the operation in progress.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        div0_d  = div0_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && inReady) begin
                    ovf_d  = 1'b0;
                    zero_d = 1'b0;
                    div0_d = 1'b0;
                    ill_d  = 1'b0;
                    cnt_d  = CNT_W'(WIDTH - 1);
                    if (bus.op == OP_MULU) begin
                        state_d = MUL;
                        lo_d    = bus.b;
                        hi_d    = '0;
                        opnd_d  = bus.a;
                    end else if (bus.op == OP_DIVU && bus.b != '0) begin
                        state_d = DIV;
                        lo_d    = bus.a;
                        hi_d    = '0;
                        opnd_d  = bus.b;
                    end else if (bus.op == OP_DIVU) begin
                        state_d = DONE;
                        lo_d    = '1;
                        hi_d    = bus.a;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        lo_d    = aluRes;
                        hi_d    = '0;
                        ovf_d   = aluOvf;
                        ill_d   = aluIll;
                        zero_d  = (aluRes == '0);
                    end
                end
            end
            MUL: begin
                hi_d  = mulSum[WIDTH:1];
                lo_d  = {mulSum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    zero_d  = (lo_d == '0);
                end
            end
            DIV: begin
                hi_d  = divFits ? divDiff : divShift[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], divFits};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    zero_d  = (lo_d == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.div0      = div0_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu
// Drives a 32-bit and an 8-bit multicycle_alu from one set of stimulus
// signals (sel8 picks the target) and compares every response against an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic        sel8 = 1'b0;
    logic [3:0]  opIn = 4'd0;
    logic [63:0] aIn = 64'd0;
    logic [63:0] bIn = 64'd0;

    logic        obsReady, obsValid;
    logic [63:0] obsRes, obsHi;
    logic [3:0]  obsFlags;

    logic [63:0] lastRes, lastHi;
    logic [3:0]  lastFlags;

    int vectors = 0;
    int miscompares = 0;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(32)) bus32 ();
    multicycle_alu_if #(.WIDTH(8))  bus8 ();

    multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    multicycle_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    // Fan the shared stimulus out to whichever DUT is selected
    assign bus32.in_valid  = inValid & ~sel8;
    assign bus32.op        = opIn;
    assign bus32.a         = aIn[31:0];
    assign bus32.b         = bIn[31:0];
    assign bus32.out_ready = outReady;
    assign bus8.in_valid   = inValid & sel8;
    assign bus8.op         = opIn;
    assign bus8.a          = aIn[7:0];
    assign bus8.b          = bIn[7:0];
    assign bus8.out_ready  = outReady;

    // Observe the selected DUT; flags packed as {overflow, zero, div0, illegal}
    always_comb begin
        if (sel8) begin
            obsReady = bus8.in_ready;
            obsValid = bus8.out_valid;
            obsRes   = {56'd0, bus8.result};
            obsHi    = {56'd0, bus8.result_hi};
            obsFlags = {bus8.overflow, bus8.zero, bus8.div0, bus8.illegal};
        end else begin
            obsReady = bus32.in_ready;
            obsValid = bus32.out_valid;
            obsRes   = {32'd0, bus32.result};
            obsHi    = {32'd0, bus32.result_hi};
            obsFlags = {bus32.overflow, bus32.zero, bus32.div0, bus32.illegal};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on w-bit values
    task automatic modelOp(input logic [3:0] op, input logic [63:0] aRaw, input logic [63:0] bRaw,
                           input int w, output logic [63:0] r, output logic [63:0] rh,
                           output logic [3:0] flags, output int lat);
        logic [63:0] mask, a, b, prod;
        longint      sa, sb, s, lim;
        logic        ovf, d0, il;
        mask = (64'd1 << w) - 64'd1;
        a    = aRaw & mask;
        b    = bRaw & mask;
        sa   = longint'(a);
        sb   = longint'(b);
        if (a[w-1]) sa = sa - longint'(64'd1 << w);
        if (b[w-1]) sb = sb - longint'(64'd1 << w);
        lim  = longint'(64'd1 << (w - 1));
        r = 64'd0; rh = 64'd0; ovf = 1'b0; d0 = 1'b0; il = 1'b0; lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin r = (a + b) & mask; s = sa + sb; ovf = (s >= lim) || (s < -lim); end
            4'd3: begin r = (a - b) & mask; s = sa - sb; ovf = (s >= lim) || (s < -lim); end
            4'd4: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd5: r = (a < b) ? 64'd1 : 64'd0;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b) & mask;
            4'd8: begin prod = a * b; r = prod & mask; rh = (prod >> w) & mask; lat = w + 1; end
            4'd9: begin
                if (b == 64'd0) begin r = mask; rh = a; d0 = 1'b1; end
                else begin r = a / b; rh = a % b; lat = w + 1; end
            end
            default: il = 1'b1;
        endcase
        flags = {ovf, (r == 64'd0), d0, il};
    endtask

    // Issue one operation, scramble the inputs while busy, measure latency,
    // check the response, hold it for 'hold' cycles, then retire it.
    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int hold);
        int          w, lat, expLat, waitCnt;
        logic [63:0] er, eh;
        logic [3:0]  ef;
        w = sel8 ? 8 : 32;
        modelOp(op, a, b, w, er, eh, ef, expLat);
        @(negedge clk);
        waitCnt = 0;
        while (!obsReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("in_ready before issue", {63'd0, obsReady}, 64'd1);
        inValid = 1'b1;
        opIn    = op;
        aIn     = a;
        bIn     = b;
        @(posedge clk);
        #1;
        inValid = 1'($urandom);
        opIn    = 4'($urandom);
        aIn     = {$urandom, $urandom};
        bIn     = {$urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!obsValid && lat < expLat + 5);
        inValid = 1'b0;
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("result", obsRes, er);
        checkOutput("result_hi", obsHi, eh);
        checkOutput("flags", {60'd0, obsFlags}, {60'd0, ef});
        checkOutput("in_ready busy", {63'd0, obsReady}, 64'd0);
        lastRes   = obsRes;
        lastHi    = obsHi;
        lastFlags = obsFlags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("held valid", {63'd0, obsValid}, 64'd1);
            checkOutput("held result", obsRes, er);
            checkOutput("held result_hi", obsHi, eh);
            checkOutput("held flags", {60'd0, obsFlags}, {60'd0, ef});
            checkOutput("held in_ready", {63'd0, obsReady}, 64'd0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("valid drop", {63'd0, obsValid}, 64'd0);
    endtask

    // Main sequence: reset, directed corner cases, random ops, reset mid-MUL
    initial begin
        int          kind, seen;
        logic [3:0]  rop;
        logic [63:0] ra, rb;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {63'd0, obsReady}, 64'd0);
        checkOutput("reset out_valid", {63'd0, obsValid}, 64'd0);
        checkOutput("reset result", obsRes, 64'd0);
        checkOutput("reset result_hi", obsHi, 64'd0);
        checkOutput("reset flags", {60'd0, obsFlags}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", {63'd0, obsReady}, 64'd1);

        sel8 = 1'b0;
        applyStimulus(4'd2, 64'h7FFFFFFF, 64'h1, 0);
        checkOutput("add ovf result", lastRes, 64'h80000000);
        checkOutput("add ovf flags", {60'd0, lastFlags}, 64'b1000);
        applyStimulus(4'd3, 64'd5, 64'd5, 0);
        checkOutput("sub zero result", lastRes, 64'd0);
        checkOutput("sub zero flags", {60'd0, lastFlags}, 64'b0100);
        applyStimulus(4'd4, 64'hFFFFFFFF, 64'd1, 0);
        checkOutput("slt result", lastRes, 64'd1);
        applyStimulus(4'd5, 64'hFFFFFFFF, 64'd1, 0);
        checkOutput("sltu result", lastRes, 64'd0);
        applyStimulus(4'd8, 64'hFFFFFFFF, 64'hFFFFFFFF, 5);
        checkOutput("mulu lo", lastRes, 64'h1);
        checkOutput("mulu hi", lastHi, 64'hFFFFFFFE);
        applyStimulus(4'd9, 64'd100, 64'd7, 0);
        checkOutput("divu quotient", lastRes, 64'd14);
        checkOutput("divu remainder", lastHi, 64'd2);
        applyStimulus(4'd9, 64'h1234, 64'd0, 1);
        checkOutput("div0 result", lastRes, 64'hFFFFFFFF);
        checkOutput("div0 result_hi", lastHi, 64'h1234);
        checkOutput("div0 flags", {60'd0, lastFlags}, 64'b0010);
        applyStimulus(4'd12, 64'hDEAD, 64'hBEEF, 0);
        checkOutput("illegal flags", {60'd0, lastFlags}, 64'b0101);

        sel8 = 1'b1;
        applyStimulus(4'd2, 64'h7F, 64'h1, 0);
        checkOutput("add8 result", lastRes, 64'h80);
        applyStimulus(4'd8, 64'hFF, 64'hFF, 2);
        checkOutput("mulu8 lo", lastRes, 64'h01);
        checkOutput("mulu8 hi", lastHi, 64'hFE);

        for (int n = 0; n < 60; n++) begin
            sel8 = 1'($urandom);
            rop  = 4'($urandom_range(0, 15));
            kind = $urandom_range(0, 3);
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if (kind == 1) rb = 64'd0;
            if (kind == 2) rb = ra;
            if (kind == 3) begin
                ra = $urandom_range(0, 1) ? 64'hFFFFFFFFFFFFFFFF : 64'h80000080;
                rb = $urandom_range(0, 1) ? 64'h1 : 64'h7FFFFF7F;
            end
            applyStimulus(rop, ra, rb, $urandom_range(0, 3));
        end

        sel8 = 1'b0;
        @(negedge clk);
        checkOutput("ready before abort", {63'd0, obsReady}, 64'd1);
        inValid = 1'b1;
        opIn    = 4'd8;
        aIn     = 64'h12345678;
        bIn     = 64'h9ABCDEF0;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", {63'd0, obsReady}, 64'd0);
        checkOutput("abort out_valid", {63'd0, obsValid}, 64'd0);
        checkOutput("abort result", obsRes, 64'd0);
        checkOutput("abort flags", {60'd0, obsFlags}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready after abort", {63'd0, obsReady}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (obsValid) seen = 1;
        end
        checkOutput("no valid after abort", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
